// File: rtl/qarctan_pkg.sv
// Shared types and fixed-point helpers for the
// streaming quadrant arctangent.
package qarctan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      DIVIDE,
      SCALE,
      OUTPUT
   } state_t;

   // Working width of the fixed-point helpers; callers
   // sign-extend into it and truncate the result back.
   localparam int MAXW = 128;

   localparam real PI_4 = 0.7853981633974483;

   function automatic int quad_one(input int bits);
      return int'(PI_4 * (2.0 ** bits));
   endfunction

   function automatic int quad_three(input int bits);
      return 3 * quad_one(bits);
   endfunction

   function automatic logic signed [MAXW-1:0] quantize(
      input logic signed [MAXW-1:0] v,
      input int                     bits
   );
      return v <<< bits;
   endfunction

   // Biased arithmetic shift: rounds toward zero.
   function automatic logic signed [MAXW-1:0] dequantize(
      input logic signed [MAXW-1:0] v,
      input int                     bits
   );
      logic signed [MAXW-1:0] bias;
      logic signed [MAXW-1:0] vb;
      bias = (MAXW'(1) <<< bits) - MAXW'(1);
      vb   = v[MAXW-1] ? v + bias : v;
      return vb >>> bits;
   endfunction

endpackage

// File: rtl/qarctan_div.sv
// Unsigned radix-2 restoring divider, WIDTH iterations
// per operation, flags a zero divisor.
module qarctan_div
   import qarctan_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] quotient
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   rem_sh;
   logic             ge;

   // Quotient register doubles as the dividend shifter.
   always_comb begin
      rem_sh = {rem, quotient[WIDTH-1]};
      ge     = rem_sh >= {1'b0, dvs};
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rem      <= '0;
         dvs      <= '0;
         cnt      <= '0;
         quotient <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dbz      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem      <= '0;
            quotient <= dividend;
            dvs      <= divisor;
            dbz      <= (divisor == '0);
            cnt      <= CW'(WIDTH);
            busy     <= 1'b1;
         end else if (busy) begin
            rem      <= WIDTH'(ge ? rem_sh - {1'b0, dvs} : rem_sh);
            quotient <= {quotient[WIDTH-2:0], ge};
            cnt      <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/qarctan_stream.sv
// Streaming quadrant arctangent atan2(y,x) in Q(BITS)
// radians with tag pass-through and valid/ready.
module qarctan_stream
   import qarctan_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BITS       = 10,
   parameter int TAG_WIDTH  = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic signed [DATA_WIDTH-1:0] y,
   input  logic [TAG_WIDTH-1:0]         in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] angle,
   output logic [TAG_WIDTH-1:0]         out_tag,
   output logic                         out_err
);

   localparam int DW = DATA_WIDTH;
   localparam int PW = 2 * DW;

   localparam logic signed [DW-1:0] Q1   = DW'(quad_one(BITS));
   localparam logic signed [DW-1:0] Q2   = DW'(2 * quad_one(BITS));
   localparam logic signed [DW-1:0] Q3   = DW'(quad_three(BITS));
   localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

   state_t state, state_nx;

   logic signed [DW-1:0]  x_q, y_q;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic                  accept;
   logic signed [DW-1:0]  ymag, ay, dif, num, den;
   logic [DW-1:0]         num_mag, den_mag, quo;
   logic                  neg, zz;
   logic                  div_start, div_busy, div_done, div_dbz;
   logic signed [DW-1:0]  r, t, a, ang;
   logic signed [PW-1:0]  prod;

   assign in_ready  = (state == IDLE) || ((state == OUTPUT) && out_ready);
   assign out_valid = (state == OUTPUT);
   assign accept    = in_valid && in_ready;
   assign div_start = (state == PREP);

   // Operands stay latched from PREP through SCALE.
   always_comb begin
      ymag = y_q[DW-1] ? -y_q : y_q;
      if (y_q == SMIN) ymag = SMAX;
      ay = ymag + DW'(1);
      if (x_q[DW-1]) begin
         dif = x_q + ay;
         den = ay - x_q;
      end else begin
         dif = x_q - ay;
         den = x_q + ay;
      end
      num     = DW'(quantize(MAXW'(dif), BITS));
      num_mag = num[DW-1] ? -num : num;
      den_mag = den[DW-1] ? -den : den;
      neg     = num[DW-1] ^ den[DW-1];
      zz      = (x_q == '0) && (y_q == '0);
      r       = neg ? -signed'(quo) : signed'(quo);
      prod    = PW'(Q1) * PW'(r);
      t       = DW'(dequantize(MAXW'(prod), BITS));
      a       = (x_q[DW-1] ? Q3 : Q1) - t;
      ang     = y_q[DW-1] ? -a : a;
   end

   qarctan_div #(
      .WIDTH(DW)
   ) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start),
      .dividend (num_mag),
      .divisor  (den_mag),
      .busy     (div_busy),
      .done     (div_done),
      .dbz      (div_dbz),
      .quotient (quo)
   );

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = PREP;
         PREP:    state_nx = DIVIDE;
         DIVIDE:  if (div_done && !div_busy) state_nx = SCALE;
         SCALE:   state_nx = OUTPUT;
         OUTPUT:  if (out_ready) state_nx = accept ? PREP : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         x_q     <= '0;
         y_q     <= '0;
         tag_q   <= '0;
         angle   <= '0;
         out_tag <= '0;
         out_err <= 1'b0;
      end else begin
         if (accept) begin
            x_q   <= x;
            y_q   <= y;
            tag_q <= in_tag;
         end
         if (state == SCALE) begin
            angle   <= zz ? Q2 : ang;
            out_tag <= tag_q;
            out_err <= div_dbz && !zz;
         end
      end
   end

endmodule
